// File: rtl/calendar_pkg.sv
// Shared widths, packed date layout and date arithmetic helpers for the
// calendar stage that follows the digital clock.
package calendar_pkg;

  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 7;
  localparam int WDAY_W = 3;
  localparam int DATE_W = WDAY_W + YEAR_W + MON_W + DAY_W;

  localparam logic [DAY_W-1:0] LEN_FEB      = 5'd28;
  localparam logic [DAY_W-1:0] LEN_FEB_LEAP = 5'd29;
  localparam logic [DAY_W-1:0] LEN_SHORT    = 5'd30;
  localparam logic [DAY_W-1:0] LEN_LONG     = 5'd31;

  localparam logic [MON_W-1:0]  MONTH_MAX = 4'd12;
  localparam logic [YEAR_W-1:0] YEAR_MAX  = 7'd99;

  typedef enum logic [WDAY_W-1:0] {
    WDAY_SUN = 3'd0,
    WDAY_MON = 3'd1,
    WDAY_TUE = 3'd2,
    WDAY_WED = 3'd3,
    WDAY_THU = 3'd4,
    WDAY_FRI = 3'd5,
    WDAY_SAT = 3'd6
  } wday_e;

  typedef struct packed {
    logic [WDAY_W-1:0] wday;
    logic [YEAR_W-1:0] year;
    logic [MON_W-1:0]  month;
    logic [DAY_W-1:0]  day;
  } date_t;

  // Leap rule year[1:0]==0 is exact across 2000-2099 only.
  function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0]  month,
                                                 input logic [YEAR_W-1:0] year);
    logic [DAY_W-1:0] len;
    case (month)
      4'd2:                      len = (year[1:0] == 2'd0) ? LEN_FEB_LEAP : LEN_FEB;
      4'd4, 4'd6, 4'd9, 4'd11:   len = LEN_SHORT;
      default:                   len = LEN_LONG;
    endcase
    return len;
  endfunction

  function automatic date_t sanitize(input date_t d);
    date_t            s;
    logic [DAY_W-1:0] len;
    s = d;
    if (d.month == 4'd0 || d.month > MONTH_MAX) s.month = 4'd1;
    if (d.year > YEAR_MAX)                      s.year  = YEAR_MAX;
    if (d.wday == 3'd7)                         s.wday  = WDAY_SUN;
    len = month_len(s.month, s.year);
    if (d.day == 5'd0)     s.day = 5'd1;
    else if (d.day > len)  s.day = len;
    return s;
  endfunction

  function automatic logic [WDAY_W-1:0] wday_next(input logic [WDAY_W-1:0] w);
    return (w == WDAY_SAT) ? WDAY_SUN : w + 3'd1;
  endfunction

  function automatic logic [WDAY_W-1:0] wday_prev(input logic [WDAY_W-1:0] w);
    return (w == WDAY_SUN) ? WDAY_SAT : w - 3'd1;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    logic [6:0] t;
    t = v % 7'd10;
    return t[3:0];
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Month length lookup (28-31) for a month/year offset pair.
module days_in_month
  import calendar_pkg::*;
(
  input  logic [MON_W-1:0]  i_month,
  input  logic [YEAR_W-1:0] i_year,
  output logic [DAY_W-1:0]  o_len
);

  assign o_len = month_len(i_month, i_year);

endmodule

// File: rtl/calendar_date.sv
// Calendar stage: advances the date on each 23->0 hour rollover and applies
// overwrite / push-button adjustments, with binary and BCD outputs.
module calendar_date
  import calendar_pkg::*;
#(
  parameter int YEAR_BASE = 2000
) (
  input  logic              clk_1hz,
  input  logic              time_reset,
  input  logic [4:0]        hour_in,
  input  logic              date_ow,
  input  logic [DATE_W-1:0] date_in,
  input  logic [DATE_W-1:0] initial_date,
  input  logic              day_inc,
  input  logic              day_dec,
  input  logic              month_inc,
  input  logic              month_dec,
  input  logic              year_inc,
  input  logic              year_dec,
  output logic [DAY_W-1:0]  day_out,
  output logic [MON_W-1:0]  month_out,
  output logic [YEAR_W-1:0] year_out,
  output logic [WDAY_W-1:0] wday_out,
  output logic [3:0]        day_1s,
  output logic [3:0]        day_10s,
  output logic [3:0]        mon_1s,
  output logic [3:0]        mon_10s,
  output logic [3:0]        yr_1s,
  output logic [3:0]        yr_10s,
  output logic              new_day
);

  // The leap rule on the year offset only holds for a base divisible by 4.
  if (YEAR_BASE % 4 != 0) begin : g_base_check
    $error("calendar_date: YEAR_BASE must be a multiple of 4");
  end

  date_t       r_date;
  logic [4:0]  r_hour_prev;
  logic [5:0]  r_btn_prev;
  logic        r_new_day;

  date_t            w_next;
  logic             w_new_day;
  logic [DAY_W-1:0] w_len;
  logic [5:0]       w_btn;
  logic [5:0]       w_edge;
  logic             w_roll;
  logic [MON_W-1:0] w_mon;
  logic [YEAR_W-1:0] w_year;
  logic [DAY_W-1:0] w_clamp;

  days_in_month u_days_in_month (
    .i_month (r_date.month),
    .i_year  (r_date.year),
    .o_len   (w_len)
  );

  // Bit order: {year_dec, year_inc, month_dec, month_inc, day_dec, day_inc}
  assign w_btn  = {year_dec, year_inc, month_dec, month_inc, day_dec, day_inc};
  assign w_edge = w_btn & ~r_btn_prev;
  assign w_roll = (r_hour_prev == 5'd23) && (hour_in == 5'd0);

  always_comb begin
    w_next    = r_date;
    w_new_day = 1'b0;
    w_mon     = r_date.month;
    w_year    = r_date.year;
    w_clamp   = '0;
    if (date_ow) begin
      w_next = sanitize(date_t'(date_in));
    end else if (w_roll) begin
      w_new_day   = 1'b1;
      w_next.wday = wday_next(r_date.wday);
      if (r_date.day < w_len) begin
        w_next.day = r_date.day + 5'd1;
      end else begin
        w_next.day = 5'd1;
        if (r_date.month == MONTH_MAX) begin
          w_next.month = 4'd1;
          w_next.year  = (r_date.year == YEAR_MAX) ? 7'd0 : r_date.year + 7'd1;
        end else begin
          w_next.month = r_date.month + 4'd1;
        end
      end
    end else if (w_edge[1:0] != 2'b00) begin
      // Simultaneous inc+dec is still the winning item; it just changes nothing.
      if (w_edge[1:0] == 2'b01) begin
        w_next.day  = (r_date.day >= w_len) ? 5'd1 : r_date.day + 5'd1;
        w_next.wday = wday_next(r_date.wday);
      end else if (w_edge[1:0] == 2'b10) begin
        w_next.day  = (r_date.day <= 5'd1) ? w_len : r_date.day - 5'd1;
        w_next.wday = wday_prev(r_date.wday);
      end
    end else if (w_edge[3:2] != 2'b00) begin
      if (w_edge[3:2] == 2'b01)
        w_mon = (r_date.month == MONTH_MAX) ? 4'd1 : r_date.month + 4'd1;
      else if (w_edge[3:2] == 2'b10)
        w_mon = (r_date.month <= 4'd1) ? MONTH_MAX : r_date.month - 4'd1;
      w_clamp      = month_len(w_mon, r_date.year);
      w_next.month = w_mon;
      w_next.day   = (r_date.day > w_clamp) ? w_clamp : r_date.day;
    end else if (w_edge[5:4] != 2'b00) begin
      if (w_edge[5:4] == 2'b01)
        w_year = (r_date.year == YEAR_MAX) ? 7'd0 : r_date.year + 7'd1;
      else if (w_edge[5:4] == 2'b10)
        w_year = (r_date.year == 7'd0) ? YEAR_MAX : r_date.year - 7'd1;
      w_clamp     = month_len(r_date.month, w_year);
      w_next.year = w_year;
      w_next.day  = (r_date.day > w_clamp) ? w_clamp : r_date.day;
    end
  end

  // Button history resets high so a button held through reset is not a press.
  always_ff @(posedge clk_1hz or posedge time_reset) begin
    if (time_reset) begin
      r_date      <= sanitize(date_t'(initial_date));
      r_hour_prev <= 5'd0;
      r_btn_prev  <= 6'b111111;
      r_new_day   <= 1'b0;
    end else begin
      r_date      <= w_next;
      r_hour_prev <= hour_in;
      r_btn_prev  <= w_btn;
      r_new_day   <= w_new_day;
    end
  end

  assign day_out   = r_date.day;
  assign month_out = r_date.month;
  assign year_out  = r_date.year;
  assign wday_out  = r_date.wday;
  assign new_day   = r_new_day;

  assign day_1s  = bcd_ones({2'b00, r_date.day});
  assign day_10s = bcd_tens({2'b00, r_date.day});
  assign mon_1s  = bcd_ones({3'b000, r_date.month});
  assign mon_10s = bcd_tens({3'b000, r_date.month});
  assign yr_1s   = bcd_ones(r_date.year);
  assign yr_10s  = bcd_tens(r_date.year);

endmodule

// File: tb/tb_calendar_date.sv
// Directed bench for calendar_date: rollovers, overwrite, buttons, sanitize, reset.
module tb_calendar_date;

  logic        clk_1hz;
  logic        time_reset;
  logic [4:0]  hour_in;
  logic        date_ow;
  logic [18:0] date_in;
  logic [18:0] initial_date;
  logic        day_inc, day_dec, month_inc, month_dec, year_inc, year_dec;
  logic [4:0]  day_out;
  logic [3:0]  month_out;
  logic [6:0]  year_out;
  logic [2:0]  wday_out;
  logic [3:0]  day_1s, day_10s, mon_1s, mon_10s, yr_1s, yr_10s;
  logic        new_day;

  int n_checks = 0;
  int n_errors = 0;

  calendar_date #(.YEAR_BASE(2000)) dut (
    .clk_1hz      (clk_1hz),
    .time_reset   (time_reset),
    .hour_in      (hour_in),
    .date_ow      (date_ow),
    .date_in      (date_in),
    .initial_date (initial_date),
    .day_inc      (day_inc),
    .day_dec      (day_dec),
    .month_inc    (month_inc),
    .month_dec    (month_dec),
    .year_inc     (year_inc),
    .year_dec     (year_dec),
    .day_out      (day_out),
    .month_out    (month_out),
    .year_out     (year_out),
    .wday_out     (wday_out),
    .day_1s       (day_1s),
    .day_10s      (day_10s),
    .mon_1s       (mon_1s),
    .mon_10s      (mon_10s),
    .yr_1s        (yr_1s),
    .yr_10s       (yr_10s),
    .new_day      (new_day)
  );

  // clock / reset
  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  function automatic logic [18:0] mk(input int w, input int y, input int m, input int d);
    logic [2:0] w3;
    logic [6:0] y7;
    logic [3:0] m4;
    logic [4:0] d5;
    w3 = w[2:0];
    y7 = y[6:0];
    m4 = m[3:0];
    d5 = d[4:0];
    return {w3, y7, m4, d5};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int y, input int m, input int d, input int w);
    chk({tag, ".year"},  32'(year_out),  y);
    chk({tag, ".month"}, 32'(month_out), m);
    chk({tag, ".day"},   32'(day_out),   d);
    chk({tag, ".wday"},  32'(wday_out),  w);
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic rollover();
    hour_in = 5'd23;
    tick();
    hour_in = 5'd0;
    tick();
  endtask

  task automatic overwrite(input logic [18:0] d);
    date_ow = 1'b1;
    date_in = d;
    tick();
    date_ow = 1'b0;
  endtask

  initial begin
    time_reset   = 1'b1;
    hour_in      = 5'd0;
    date_ow      = 1'b0;
    date_in      = '0;
    initial_date = mk(3, 24, 2, 28);
    {day_inc, day_dec, month_inc, month_dec, year_inc, year_dec} = 6'b0;
    #12;

    chk_date("reset", 24, 2, 28, 3);
    chk("reset.new_day", 32'(new_day), 0);
    chk("reset.day_bcd", {24'd0, day_10s, day_1s}, 32'h28);
    chk("reset.mon_bcd", {24'd0, mon_10s, mon_1s}, 32'h02);
    chk("reset.yr_bcd",  {24'd0, yr_10s, yr_1s},   32'h24);

    tick();
    time_reset = 1'b0;
    tick();

    rollover();
    chk_date("roll_leap", 24, 2, 29, 4);
    chk("roll_leap.new_day", 32'(new_day), 1);
    tick();
    chk("roll_leap.strobe_drop", 32'(new_day), 0);
    chk_date("roll_leap.hold", 24, 2, 29, 4);

    rollover();
    chk_date("roll_mar", 24, 3, 1, 5);
    chk("roll_mar.new_day", 32'(new_day), 1);

    overwrite(mk(2, 23, 2, 28));
    chk_date("ow_2023", 23, 2, 28, 2);
    rollover();
    chk_date("roll_nonleap", 23, 3, 1, 3);

    overwrite(mk(4, 99, 12, 31));
    rollover();
    chk_date("roll_century", 0, 1, 1, 5);
    chk("roll_century.yr_bcd", {24'd0, yr_10s, yr_1s}, 32'h00);

    overwrite(mk(0, 24, 3, 31));
    month_dec = 1'b1;
    tick();
    chk_date("month_dec_clamp", 24, 2, 29, 0);
    month_dec = 1'b0;
    tick();
    year_inc = 1'b1;
    tick();
    chk_date("year_inc_clamp", 25, 2, 28, 0);
    tick();
    chk_date("year_inc_held", 25, 2, 28, 0);
    year_inc = 1'b0;
    tick();
    day_inc = 1'b1;
    tick();
    chk_date("day_inc_wrap", 25, 2, 1, 1);
    day_inc = 1'b0;
    tick();
    day_dec = 1'b1;
    tick();
    chk_date("day_dec_wrap", 25, 2, 28, 0);
    day_dec = 1'b0;
    tick();

    overwrite(mk(1, 10, 5, 10));
    day_inc = 1'b1;
    day_dec = 1'b1;
    month_inc = 1'b1;
    tick();
    chk_date("day_both_preempts_month", 10, 5, 10, 1);
    {day_inc, day_dec, month_inc} = 3'b0;
    tick();

    overwrite(mk(0, 24, 12, 15));
    month_inc = 1'b1;
    tick();
    chk_date("month_inc_wrap", 24, 1, 15, 0);
    month_inc = 1'b0;
    overwrite(mk(6, 0, 5, 10));
    year_dec = 1'b1;
    tick();
    chk_date("year_dec_wrap", 99, 5, 10, 6);
    year_dec = 1'b0;
    tick();

    overwrite(mk(7, 120, 13, 0));
    chk_date("sanitize_range", 99, 1, 1, 0);
    overwrite(mk(1, 23, 2, 31));
    chk_date("sanitize_daylen", 23, 2, 28, 1);

    day_inc = 1'b1;
    time_reset = 1'b1;
    #1;
    chk_date("async_reset", 24, 2, 28, 3);
    tick();
    time_reset = 1'b0;
    tick();
    tick();
    chk_date("held_through_reset", 24, 2, 28, 3);
    day_inc = 1'b0;
    tick();

    hour_in = 5'd23;
    tick();
    hour_in = 5'd0;
    date_ow = 1'b1;
    date_in = mk(2, 10, 6, 15);
    tick();
    date_ow = 1'b0;
    chk_date("ow_beats_roll", 10, 6, 15, 2);
    chk("ow_beats_roll.new_day", 32'(new_day), 0);

    hour_in = 5'd23;
    tick();
    chk_date("hour_0_to_23", 10, 6, 15, 2);
    chk("hour_0_to_23.new_day", 32'(new_day), 0);
    hour_in = 5'd22;
    tick();
    hour_in = 5'd23;
    tick();
    chk_date("hour_22_to_23", 10, 6, 15, 2);
    chk("hour_22_to_23.new_day", 32'(new_day), 0);
    hour_in = 5'd5;
    tick();
    chk_date("hour_23_to_5", 10, 6, 15, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calendar_date.md
# calendar_date

Calendar stage directly downstream of the digital clock: watches the clock's 5-bit binary hour output and advances a day/month/year/weekday date on every midnight rollover. Covers years 2000–2099 with leap-year handling and supports overwrite, reset-to-initial and push-button date adjustment. Provides binary and BCD date fields for the display stage, plus a one-cycle `new_day` strobe.

## Interface
- `YEAR_BASE`, default 2000: documentation only; year fields are an offset 0–99 from this base.
- `clk_1hz`  in  1  1 Hz clock, shared with the clock stage.
- `time_reset`  in  1  Reset: asynchronous, active-high. Loads `initial_date`.
- `hour_in`  in  5  Binary hour (0–23) from the clock stage.
- `date_ow`  in  1  Synchronous overwrite with `date_in` while high.
- `date_in`  in  19  `{wday[2:0], year[6:0], month[3:0], day[4:0]}`.
- `initial_date`  in  19  Same format as `date_in`; loaded on reset.
- `day_inc`, `day_dec`, `month_inc`, `month_dec`, `year_inc`, `year_dec`  in  1 each  Adjust buttons. Level inputs, acted on at the rising edge.
- `day_out`  out  5  Day, 1–31.
- `month_out`  out  4  Month, 1–12.
- `year_out`  out  7  Year offset, 0–99.
- `wday_out`  out  3  Weekday, 0 = Sunday … 6 = Saturday.
- `day_1s`, `day_10s`, `mon_1s`, `mon_10s`, `yr_1s`, `yr_10s`  out  4 each  BCD digits.
- `new_day`  out  1  One-cycle strobe on a rollover advance.

## Operation
- **Registers:** `day`, `month`, `year`, `wday`, `hour_prev[4:0]`, six button-previous bits, `new_day`.
- **Reset (async):**
  - Date fields are loaded from the sanitized `initial_date`.
  - `hour_prev` = 0.
  - Button-previous bits = 1, so a button held through reset release is not seen as a press.
  - `new_day` = 0.
- **Rising edge** of a button = current sample is 1 and previous sample is 0.
- **Per-edge priority:** `date_ow` > rollover > day buttons > month buttons > year buttons. Only the highest active item acts.
  - Button-previous bits and `hour_prev` update on every edge regardless of priority.
  - A press that is pre-empted is therefore lost.
- **Sanitize** (applied to `date_in` and `initial_date`):
  - month 0 or >12 → 1.
  - year >99 → 99.
  - wday 7 → 0.
  - day 0 → 1; day > `days_in_month(month, year)` → that month length. Uses the already-sanitized month and year.
- **Rollover:** condition is `hour_prev == 23 && hour_in == 0`. Any 23→0 transition counts, including a manual hour increment.
  - `wday` = (wday+1) mod 7.
  - If day < length: day+1.
  - Else day = 1; month+1, or if month = 12: month = 1 and year = (year+1) mod 100.
  - `new_day` is 1 for this cycle only.
  - A 0→23 transition has no effect.
- **Day buttons:**
  - inc and dec together → no change.
  - inc: day wraps from the month length to 1; wday+1 mod 7.
  - dec: day wraps from 1 to the month length; wday−1 mod 7.
  - Month and year are not changed.
- **Month buttons:**
  - inc and dec together → no change.
  - Month wraps 12↔1 and the year is not changed.
  - Day is then clamped to the new month's length.
  - wday is unchanged.
- **Year buttons:**
  - inc and dec together → no change.
  - Year wraps 99↔0.
  - Day is clamped, so Feb 29 → 28 in a non-leap year.
  - wday is unchanged.
- **Leap year:** `year[1:0] == 0`. Exact for 2000–2099.
- **BCD digits:** combinational /10 and %10 of the binary registers.

## Timing
- The clock stage wraps hour 23→0 at edge N. The calendar samples the condition at edge N+1, the date updates at edge N+1, and `new_day` is high from N+1 to N+2.
- `date_ow` takes effect at the next edge; outputs are valid one edge after assertion. A rollover on that same edge is discarded.
- Button response: press sampled at edge K (previous = 0) → field updated at edge K.
- `time_reset` acts immediately, without waiting for a clock edge, including mid-adjust or during a rollover cycle. `new_day` drops to 0.

## Structure
- **`calendar_pkg`:**
  - field widths;
  - `date_t` packed struct `{wday, year, month, day}`;
  - month-length constants;
  - `WDAY_SUN` = 0 … `WDAY_SAT` = 6;
  - the sanitize function.
- **Sub-module `days_in_month`:** combinational `(month[3:0], year[6:0]) → len[4:0]` (28–31). Instantiated once for the live date. The sanitize and clamp paths reuse the same function from the package.

## Test plan
- Reset to 2024-02-28, wday 3; hour 23→0 → 2024-02-29, wday 4, `new_day` for one cycle. Second rollover → 2024-03-01, wday 5.
- `date_ow` 2023-02-28 wday 2; rollover → 2023-03-01, wday 3. `date_ow` 99-12-31 wday 4; rollover → 00-01-01, wday 5.
- `date_ow` 2024-03-31 wday 0; `month_dec` edge → 2024-02-29. `year_inc` edge → 2025-02-28. `day_inc` edge → 2025-02-01, wday 1.
- `date_ow` with month 13, day 0, year 120, wday 7 → 99-01-01, wday 0.
- `day_inc` held across `time_reset` deassert → no change. `date_ow` and rollover on the same edge → `date_in` wins and `new_day` = 0.
- Hour 0→23 and hour 22→23 → no date change; `new_day` stays 0.
